// File: rtl/avl_arbiter.sv
// Two-port (imem/dmem) arbiter in front of a single-outstanding Avalon bridge.
// Define AVL_ARBITER_ROUND_ROBIN_EN for round-robin tie-breaks; default build gives dmem priority.
module avl_arbiter (
  input  logic        clock,
  input  logic        reset,
  input  logic        imem_valid,
  input  logic [31:0] imem_addr,
  output logic [31:0] imem_rdata,
  output logic        imem_ready,
  input  logic        dmem_valid,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_rdata,
  output logic        dmem_ready,
  output logic        avl_valid,
  output logic        avl_instr,
  output logic [31:0] avl_addr,
  output logic [31:0] avl_wdata,
  output logic [3:0]  avl_wstrb,
  input  logic [31:0] avl_rdata,
  input  logic        avl_ready
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic        owner_imem_q, owner_imem_d;

  logic        ipend_q;
  logic [31:0] iaddr_q;
  logic        dpend_q;
  logic [31:0] daddr_q;
  logic [31:0] dwdata_q;
  logic [3:0]  dwstrb_q;

  logic        grant_imem;

`ifdef AVL_ARBITER_ROUND_ROBIN_EN
  logic        last_imem_q, last_imem_d;
`endif

  always_comb begin
    state_d      = state_q;
    owner_imem_d = owner_imem_q;
    grant_imem   = 1'b0;
`ifdef AVL_ARBITER_ROUND_ROBIN_EN
    last_imem_d  = last_imem_q;
`endif
    avl_valid    = 1'b0;
    avl_instr    = 1'b0;
    avl_addr     = '0;
    avl_wdata    = '0;
    avl_wstrb    = '0;
    imem_ready   = 1'b0;
    imem_rdata   = '0;
    dmem_ready   = 1'b0;
    dmem_rdata   = '0;

    unique case (state_q)
      IDLE: begin
        if (ipend_q || dpend_q) begin
          if (ipend_q && dpend_q) begin
`ifdef AVL_ARBITER_ROUND_ROBIN_EN
            grant_imem = ~last_imem_q;
`else
            grant_imem = 1'b0;
`endif
          end else begin
            grant_imem = ipend_q;
          end
          avl_valid    = 1'b1;
          avl_instr    = grant_imem;
          avl_addr     = grant_imem ? iaddr_q : daddr_q;
          avl_wdata    = grant_imem ? '0 : dwdata_q;
          avl_wstrb    = grant_imem ? '0 : dwstrb_q;
          owner_imem_d = grant_imem;
`ifdef AVL_ARBITER_ROUND_ROBIN_EN
          last_imem_d  = grant_imem;
`endif
          state_d      = BUSY;
        end
      end
      BUSY: begin
        // A completion arriving alongside reset belongs to an abandoned request.
        if (avl_ready && !reset) begin
          if (owner_imem_q) begin
            imem_ready = 1'b1;
            imem_rdata = avl_rdata;
          end else begin
            dmem_ready = 1'b1;
            dmem_rdata = avl_rdata;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_imem_q <= 1'b0;
      ipend_q      <= 1'b0;
      iaddr_q      <= '0;
      dpend_q      <= 1'b0;
      daddr_q      <= '0;
      dwdata_q     <= '0;
      dwstrb_q     <= '0;
`ifdef AVL_ARBITER_ROUND_ROBIN_EN
      last_imem_q  <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      owner_imem_q <= owner_imem_d;
`ifdef AVL_ARBITER_ROUND_ROBIN_EN
      last_imem_q  <= last_imem_d;
`endif
      // Slot stays occupied while in flight; its own ready frees it for a same-cycle refill.
      if (imem_valid && (!ipend_q || imem_ready)) begin
        ipend_q <= 1'b1;
        iaddr_q <= imem_addr;
      end else if (imem_ready) begin
        ipend_q <= 1'b0;
      end

      if (dmem_valid && (!dpend_q || dmem_ready)) begin
        dpend_q  <= 1'b1;
        daddr_q  <= dmem_addr;
        dwdata_q <= dmem_wdata;
        dwstrb_q <= dmem_wstrb;
      end else if (dmem_ready) begin
        dpend_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_avl_arbiter.sv
// Self-checking bench for avl_arbiter: directed scenarios plus a randomized run against a slot model.
module tb_avl_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_valid;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        dmem_valid;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;
  logic        avl_valid;
  logic        avl_instr;
  logic [31:0] avl_addr;
  logic [31:0] avl_wdata;
  logic [3:0]  avl_wstrb;
  logic [31:0] avl_rdata;
  logic        avl_ready;

  int n_err = 0;
  int n_chk = 0;

`ifdef AVL_ARBITER_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  always #5 clock = ~clock;

  avl_arbiter dut (
    .clock      (clock),
    .reset      (reset),
    .imem_valid (imem_valid),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ready (imem_ready),
    .dmem_valid (dmem_valid),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_wstrb (dmem_wstrb),
    .dmem_rdata (dmem_rdata),
    .dmem_ready (dmem_ready),
    .avl_valid  (avl_valid),
    .avl_instr  (avl_instr),
    .avl_addr   (avl_addr),
    .avl_wdata  (avl_wdata),
    .avl_wstrb  (avl_wstrb),
    .avl_rdata  (avl_rdata),
    .avl_ready  (avl_ready)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_in();
    imem_valid = 1'b0; imem_addr  = '0;
    dmem_valid = 1'b0; dmem_addr  = '0; dmem_wdata = '0; dmem_wstrb = '0;
    avl_ready  = 1'b0; avl_rdata  = '0;
  endtask

  task automatic do_reset();
    idle_in();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_chk++;
    if ({avl_valid, avl_instr, avl_addr, avl_wdata, avl_wstrb} !== 70'h0) begin
      n_err++;
      $display("FAIL reset_avl: got %0h want 0", {avl_valid, avl_instr, avl_addr, avl_wdata, avl_wstrb});
    end
    n_chk++;
    if ({imem_ready, imem_rdata, dmem_ready, dmem_rdata} !== 66'h0) begin
      n_err++;
      $display("FAIL reset_resp: got %0h want 0", {imem_ready, imem_rdata, dmem_ready, dmem_rdata});
    end
    avl_ready = 1'b1; avl_rdata = 32'hCAFE0001;
    #1;
    n_chk++;
    if ({imem_ready, dmem_ready} !== 2'b00) begin
      n_err++;
      $display("FAIL idle_ready_ignored: got %b want 00", {imem_ready, dmem_ready});
    end
    tick();
    idle_in();
  endtask

  task automatic test_single_fetch();
    do_reset();
    imem_valid = 1'b1; imem_addr = 32'h0000_0100;
    tick();
    idle_in();
    #1;
    n_chk++;
    if ({avl_valid, avl_instr, avl_addr, avl_wdata, avl_wstrb} !== {1'b1, 1'b1, 32'h100, 32'h0, 4'h0}) begin
      n_err++;
      $display("FAIL fetch_issue: got %0h want %0h", {avl_valid, avl_instr, avl_addr, avl_wdata, avl_wstrb},
               {1'b1, 1'b1, 32'h100, 32'h0, 4'h0});
    end
    tick();
    n_chk++;
    if ({avl_valid, imem_ready, dmem_ready} !== 3'b000) begin
      n_err++;
      $display("FAIL fetch_busy_quiet: got %b want 000", {avl_valid, imem_ready, dmem_ready});
    end
    tick();
    tick();
    avl_ready = 1'b1; avl_rdata = 32'hDEADBEEF;
    #1;
    n_chk++;
    if ({imem_ready, imem_rdata, dmem_ready, dmem_rdata} !== {1'b1, 32'hDEADBEEF, 1'b0, 32'h0}) begin
      n_err++;
      $display("FAIL fetch_ready: got %0h want %0h", {imem_ready, imem_rdata, dmem_ready, dmem_rdata},
               {1'b1, 32'hDEADBEEF, 1'b0, 32'h0});
    end
    tick();
    idle_in();
    #1;
    n_chk++;
    if ({avl_valid, imem_ready, imem_rdata} !== 34'h0) begin
      n_err++;
      $display("FAIL fetch_after: got %0h want 0", {avl_valid, imem_ready, imem_rdata});
    end
  endtask

  task automatic test_store();
    do_reset();
    dmem_valid = 1'b1; dmem_addr = 32'h2000; dmem_wdata = 32'h12345678; dmem_wstrb = 4'h3;
    tick();
    idle_in();
    #1;
    n_chk++;
    if ({avl_valid, avl_instr, avl_addr, avl_wdata, avl_wstrb} !== {1'b1, 1'b0, 32'h2000, 32'h12345678, 4'h3}) begin
      n_err++;
      $display("FAIL store_issue: got %0h want %0h", {avl_valid, avl_instr, avl_addr, avl_wdata, avl_wstrb},
               {1'b1, 1'b0, 32'h2000, 32'h12345678, 4'h3});
    end
    tick();
    avl_ready = 1'b1; avl_rdata = 32'h0;
    #1;
    n_chk++;
    if ({dmem_ready, dmem_rdata, imem_ready} !== {1'b1, 32'h0, 1'b0}) begin
      n_err++;
      $display("FAIL store_ready: got %0h want %0h", {dmem_ready, dmem_rdata, imem_ready}, {1'b1, 32'h0, 1'b0});
    end
    tick();
    idle_in();
  endtask

  task automatic test_simultaneous();
    logic [36:0] exp2, exp3;
    exp2 = RR ? {1'b1, 32'h100, 4'h0} : {1'b0, 32'h2004, 4'h0};
    exp3 = RR ? {1'b0, 32'h2004, 4'h0} : {1'b1, 32'h100, 4'h0};
    do_reset();
    imem_valid = 1'b1; imem_addr = 32'h100;
    dmem_valid = 1'b1; dmem_addr = 32'h2000;
    tick();
    idle_in();
    #1;
    n_chk++;
    if ({avl_valid, avl_instr, avl_addr} !== {1'b1, 1'b0, 32'h2000}) begin
      n_err++;
      $display("FAIL tie_first: got %0h want %0h", {avl_valid, avl_instr, avl_addr}, {1'b1, 1'b0, 32'h2000});
    end
    tick();
    avl_ready = 1'b1; avl_rdata = 32'hA5A5A5A5;
    imem_valid = 1'b1; imem_addr = 32'h104;
    dmem_valid = 1'b1; dmem_addr = 32'h2004;
    #1;
    n_chk++;
    if ({dmem_ready, dmem_rdata, imem_ready} !== {1'b1, 32'hA5A5A5A5, 1'b0}) begin
      n_err++;
      $display("FAIL tie_first_ready: got %0h want %0h", {dmem_ready, dmem_rdata, imem_ready},
               {1'b1, 32'hA5A5A5A5, 1'b0});
    end
    tick();
    idle_in();
    #1;
    n_chk++;
    if ({avl_valid, avl_instr, avl_addr, avl_wstrb} !== {1'b1, exp2}) begin
      n_err++;
      $display("FAIL tie_second: got %0h want %0h", {avl_valid, avl_instr, avl_addr, avl_wstrb}, {1'b1, exp2});
    end
    tick();
    avl_ready = 1'b1; avl_rdata = 32'h1111_2222;
    #1;
    n_chk++;
    if ({imem_ready, dmem_ready} !== (RR ? 2'b10 : 2'b01)) begin
      n_err++;
      $display("FAIL tie_second_ready: got %b want %b", {imem_ready, dmem_ready}, (RR ? 2'b10 : 2'b01));
    end
    tick();
    idle_in();
    #1;
    n_chk++;
    if ({avl_valid, avl_instr, avl_addr, avl_wstrb} !== {1'b1, exp3}) begin
      n_err++;
      $display("FAIL tie_third: got %0h want %0h", {avl_valid, avl_instr, avl_addr, avl_wstrb}, {1'b1, exp3});
    end
    tick();
    avl_ready = 1'b1;
    tick();
    idle_in();
  endtask

  task automatic test_back_to_back();
    do_reset();
    dmem_valid = 1'b1; dmem_addr = 32'h3000; dmem_wdata = 32'h1; dmem_wstrb = 4'hF;
    tick();
    idle_in();
    tick();
    dmem_valid = 1'b1; dmem_addr = 32'h3BAD; dmem_wdata = 32'hBAD; dmem_wstrb = 4'h1;
    tick();
    dmem_valid = 1'b1; dmem_addr = 32'h3008; dmem_wdata = 32'h8; dmem_wstrb = 4'hC;
    avl_ready = 1'b1; avl_rdata = 32'h55;
    #1;
    n_chk++;
    if ({dmem_ready, dmem_rdata} !== {1'b1, 32'h55}) begin
      n_err++;
      $display("FAIL b2b_ready: got %0h want %0h", {dmem_ready, dmem_rdata}, {1'b1, 32'h55});
    end
    tick();
    idle_in();
    #1;
    n_chk++;
    if ({avl_valid, avl_instr, avl_addr, avl_wdata, avl_wstrb} !== {1'b1, 1'b0, 32'h3008, 32'h8, 4'hC}) begin
      n_err++;
      $display("FAIL b2b_reissue: got %0h want %0h", {avl_valid, avl_instr, avl_addr, avl_wdata, avl_wstrb},
               {1'b1, 1'b0, 32'h3008, 32'h8, 4'hC});
    end
    tick();
    avl_ready = 1'b1;
    tick();
    idle_in();
    #1;
    n_chk++;
    if (avl_valid !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_dropped: got %b want 0", avl_valid);
    end
  endtask

  task automatic test_reset_busy();
    do_reset();
    imem_valid = 1'b1; imem_addr = 32'h400;
    dmem_valid = 1'b1; dmem_addr = 32'h5000;
    tick();
    idle_in();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    n_chk++;
    if (avl_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_busy_idle: got %b want 0", avl_valid);
    end
    avl_ready = 1'b1; avl_rdata = 32'h7777;
    #1;
    n_chk++;
    if ({imem_ready, dmem_ready} !== 2'b00) begin
      n_err++;
      $display("FAIL rst_busy_noready: got %b want 00", {imem_ready, dmem_ready});
    end
    tick();
    idle_in();
    #1;
    n_chk++;
    if (avl_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_busy_slots: got %b want 0", avl_valid);
    end
  endtask

  // Model: index 0 = imem, 1 = dmem; one pending slot each, at most one in flight.
  bit          m_busy;
  int          m_owner;
  int          m_last;
  bit          m_pend [2];
  logic [31:0] m_addr [2];
  logic [31:0] m_wdata[2];
  logic [3:0]  m_wstrb[2];

  task automatic test_random();
    int          win, wait_cnt;
    bit          vin;
    logic [69:0] e_avl;
    logic [32:0] e_resp[2];
    do_reset();
    m_busy = 1'b0; m_owner = 0; m_last = 0; wait_cnt = 0;
    for (int p = 0; p < 2; p++) begin
      m_pend[p] = 1'b0; m_addr[p] = '0; m_wdata[p] = '0; m_wstrb[p] = '0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      imem_valid = ($urandom_range(0, 2) == 0);
      imem_addr  = $urandom;
      dmem_valid = ($urandom_range(0, 2) == 0);
      dmem_addr  = $urandom;
      dmem_wdata = $urandom;
      dmem_wstrb = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      avl_rdata  = $urandom;
      if (m_busy) begin
        if (wait_cnt == 0) avl_ready = 1'b1;
        else begin avl_ready = 1'b0; wait_cnt--; end
      end else begin
        avl_ready = ($urandom_range(0, 7) == 0);
      end
      #1;
      win = -1;
      e_avl = '0;
      e_resp[0] = '0;
      e_resp[1] = '0;
      if (!m_busy && (m_pend[0] || m_pend[1])) begin
        if (m_pend[0] && m_pend[1]) win = RR ? (m_last == 0 ? 1 : 0) : 1;
        else                        win = m_pend[0] ? 0 : 1;
        e_avl = {1'b1, (win == 0), m_addr[win], m_wdata[win], m_wstrb[win]};
      end
      if (m_busy && avl_ready) e_resp[m_owner] = {1'b1, avl_rdata};
      n_chk++;
      if ({avl_valid, avl_instr, avl_addr, avl_wdata, avl_wstrb} !== e_avl) begin
        n_err++;
        $display("FAIL rand_avl cyc=%0d: got %0h want %0h", cyc,
                 {avl_valid, avl_instr, avl_addr, avl_wdata, avl_wstrb}, e_avl);
      end
      n_chk++;
      if ({imem_ready, imem_rdata} !== e_resp[0]) begin
        n_err++;
        $display("FAIL rand_imem cyc=%0d: got %0h want %0h", cyc, {imem_ready, imem_rdata}, e_resp[0]);
      end
      n_chk++;
      if ({dmem_ready, dmem_rdata} !== e_resp[1]) begin
        n_err++;
        $display("FAIL rand_dmem cyc=%0d: got %0h want %0h", cyc, {dmem_ready, dmem_rdata}, e_resp[1]);
      end
      for (int p = 0; p < 2; p++) begin
        vin = (p == 0) ? imem_valid : dmem_valid;
        if (vin && (!m_pend[p] || e_resp[p][32])) begin
          m_pend[p]  = 1'b1;
          m_addr[p]  = (p == 0) ? imem_addr : dmem_addr;
          m_wdata[p] = (p == 0) ? 32'h0 : dmem_wdata;
          m_wstrb[p] = (p == 0) ? 4'h0 : dmem_wstrb;
        end else if (e_resp[p][32]) begin
          m_pend[p] = 1'b0;
        end
      end
      if (win >= 0) begin
        m_busy = 1'b1; m_owner = win; m_last = win;
        wait_cnt = $urandom_range(0, 3);
      end else if (m_busy && avl_ready) begin
        m_busy = 1'b0;
      end
      tick();
    end
    idle_in();
  endtask

  initial begin
    idle_in();
    reset = 1'b1;
    test_reset();
    test_single_fetch();
    test_store();
    test_simultaneous();
    test_back_to_back();
    test_reset_busy();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/avl_arbiter.md
AVL_ARBITER -- requirements
Module: avl_arbiter

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 Port `clock`: input, 1 bit, rising-edge clock for all state.
REQ-004 Port `reset`: input, 1 bit, synchronous, active-high.
REQ-005 Port `imem_valid`: input, 1 bit, single-cycle fetch request pulse.
REQ-006 Port `imem_addr`: input, 32 bits, fetch address.
REQ-007 Port `imem_rdata`: output, 32 bits, fetch read data.
REQ-008 Port `imem_ready`: output, 1 bit, fetch completion pulse.
REQ-009 Port `dmem_valid`: input, 1 bit, single-cycle data request pulse.
REQ-010 Port `dmem_addr`: input, 32 bits, data address.
REQ-011 Port `dmem_wdata`: input, 32 bits, store data.
REQ-012 Port `dmem_wstrb`: input, 4 bits, byte strobes; 0 means load.
REQ-013 Port `dmem_rdata`: output, 32 bits, load data.
REQ-014 Port `dmem_ready`: output, 1 bit, data completion pulse.
REQ-015 Port `avl_valid`: output, 1 bit, request pulse to the Avalon bridge.
REQ-016 Port `avl_instr`: output, 1 bit, 1 when the granted requester is imem.
REQ-017 Port `avl_addr`: output, 32 bits, bridge request address.
REQ-018 Port `avl_wdata`: output, 32 bits, bridge write data.
REQ-019 Port `avl_wstrb`: output, 4 bits, bridge byte strobes.
REQ-020 Port `avl_rdata`: input, 32 bits, bridge read data.
REQ-021 Port `avl_ready`: input, 1 bit, bridge completion pulse.

Function
REQ-022 Each port SHALL have one pending slot; on `*_valid`=1, addr/wdata/wstrb SHALL be captured into it at the clock edge.
- For imem, wstrb is captured as 0 and wdata as 0.
REQ-023 A `*_valid` while that port's slot is pending or in flight SHALL be ignored, except in the cycle where that port's `*_ready`=1, when it SHALL be captured.
REQ-024 The block SHALL have two states, IDLE and BUSY.
REQ-025 In IDLE with at least one slot pending, the block SHALL:
- drive `avl_valid`=1 for exactly one cycle with the winner's payload;
- set `avl_instr` to match the winner;
- record the owner;
- go to BUSY at the next edge.
REQ-026 In BUSY, when `avl_ready`=1, the block SHALL in the same cycle:
- drive the owner's `*_ready`=1 and `*_rdata`=`avl_rdata`;
- clear the owner's slot;
- return to IDLE at the next edge.
REQ-027 The minimum latency from a `*_valid` on an idle block to `avl_valid` SHALL be 1 cycle.
REQ-028 A new grant SHALL be issued no earlier than the cycle after `avl_ready`.
REQ-029 At most one request SHALL be outstanding downstream at any time.
REQ-030 Outside IDLE-issue cycles, all `avl_*` request outputs SHALL be 0.
REQ-031 `*_rdata` SHALL be 0 whenever the corresponding `*_ready`=0.
REQ-032 `imem_ready` and `dmem_ready` SHALL never be 1 in the same cycle.
REQ-033 `avl_ready` in IDLE SHALL be ignored.

Reset
REQ-034 During reset, the block SHALL clear both pending slots, set the state to IDLE, and set the last-grant register to imem.
REQ-035 All outputs SHALL be 0 in the cycle following reset.
REQ-036 Reset during BUSY SHALL abandon the in-flight request; no `*_ready` SHALL be produced for it.

Configuration
REQ-037 The macro `AVL_ARBITER_ROUND_ROBIN_EN` SHALL select the tie-break policy when both slots are pending in IDLE.
REQ-038 With `AVL_ARBITER_ROUND_ROBIN_EN` defined, the grant SHALL go to the port that did not win the most recent grant; the last-grant register updates on every grant.
REQ-039 Without `AVL_ARBITER_ROUND_ROBIN_EN`, dmem SHALL always win ties, and the last-grant register is unused.

Verification
REQ-040 Single fetch: imem_valid at cycle 0 with addr 0x00000100 -> avl_valid=1 and avl_instr=1 with addr 0x100 at cycle 1; avl_ready with rdata 0xDEADBEEF at cycle 4 -> imem_ready=1 and imem_rdata=0xDEADBEEF at cycle 4.
REQ-041 Store: dmem_valid with addr 0x2000, wdata 0x12345678, wstrb 0x3 -> avl_valid with the same payload and avl_instr=0 one cycle later; dmem_ready on avl_ready; dmem_rdata=0.
REQ-042 Simultaneous requests at cycle 0 (imem 0x100, dmem 0x2000):
- Round-robin build: dmem is granted first; imem is issued the cycle after dmem completes.
- Fixed build, with a repeated imem+dmem pair after the first completes: dmem wins both ties.
REQ-043 Back-to-back: dmem_valid in the same cycle as dmem_ready -> captured and reissued one cycle after the ready; a repeat valid mid-flight is dropped.
REQ-044 Reset asserted in BUSY before avl_ready:
- All slots are cleared and the state returns to IDLE.
- A subsequent avl_ready pulse produces no imem_ready or dmem_ready.
